// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;

    localparam logic PORT_FILTER = 1'b0;
    localparam logic PORT_HOST   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick with a last-granted pointer that moves only on grant.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       winner_c,
    output logic       any_req_c,
    output logic       last_grant
);

    logic last_q;
    logic last_d;

    // Pick the requester; on a tie the port not granted last wins.
    always_comb begin
        any_req_c = |req;
        winner_c  = PORT_FILTER;
        if (req == 2'b11) begin
            winner_c = ~last_q;
        end else if (req[1]) begin
            winner_c = PORT_HOST;
        end
        last_d = grant_en ? winner_c : last_q;
    end

    // Last-granted pointer; starts at the host so the filter wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_HOST;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/ram_arbiter.sv
// Serialises filter and host accesses onto a single strobed RAM port.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    input  logic              Write0,
    input  logic              Write1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemClk,
    output logic              MemWrite,
    inout  wire  [DATA_W-1:0] MemData,
    output logic              Busy,
    output logic              GrantId
);

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                write_q,  write_d;
    logic                oe_q,     oe_d;
    logic                mclk_q,   mclk_d;
    logic [1:0]          ack_q,    ack_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q,   busy_d;

    logic winner_c;
    logic any_req_c;
    logic grant_en_c;
    logic last_grant;

    assign grant_en_c = (state_q == IDLE) && any_req_c;

    rr_arb2 u_rr_arb2 (
        .clk        (Clock),
        .rst        (Reset),
        .req        ({Req1, Req0}),
        .grant_en   (grant_en_c),
        .winner_c   (winner_c),
        .any_req_c  (any_req_c),
        .last_grant (last_grant)
    );

    // Access sequencer: latch on grant, raise the strobe, capture read data, ack.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        oe_d     = oe_q;
        mclk_d   = 1'b0;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                write_d = 1'b0;
                oe_d    = 1'b0;
                if (any_req_c) begin
                    state_d = SETUP;
                    if (winner_c == PORT_HOST) begin
                        addr_d  = Addr1;
                        wdata_d = WData1;
                        write_d = Write1;
                    end else begin
                        addr_d  = Addr0;
                        wdata_d = WData0;
                        write_d = Write0;
                    end
                    oe_d = write_d;
                end
            end
            SETUP: begin
                state_d = STROBE;
                mclk_d  = 1'b1;
            end
            STROBE: begin
                state_d = DONE;
                if (last_grant == PORT_HOST) begin
                    ack_d[1] = 1'b1;
                    if (!write_q) rdata1_d = MemData;
                end else begin
                    ack_d[0] = 1'b1;
                    if (!write_q) rdata0_d = MemData;
                end
            end
            DONE: begin
                state_d = IDLE;
                write_d = 1'b0;
                oe_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            oe_q     <= 1'b0;
            mclk_q   <= 1'b0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            oe_q     <= oe_d;
            mclk_q   <= mclk_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign MemData  = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign MemAddr  = addr_q;
    assign MemClk   = mclk_q;
    assign MemWrite = write_q;
    assign Ack0     = ack_q[0];
    assign Ack1     = ack_q[1];
    assign RData0   = rdata0_q;
    assign RData1   = rdata1_q;
    assign Busy     = busy_q;
    assign GrantId  = last_grant;

endmodule
